fifo_word_packer: RTL and testbench
===================================

Name: fifo_word_packer

Overview:
- Downstream consumer of the word FIFO.
- Pops word_t entries using the FIFO's valid/yumi handshake and packs PACK consecutive words into one wide beat.
- Presents the beat to the next stage with a valid/ready handshake.
- Supports flushing a partial beat, with a per-lane keep mask.

Parameters:
- PACK, 4: words per output beat; legal range 2..8.
- W, $bits(fifo_types::word_t): lane width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- valid_i  in  1  FIFO has a word (connects to FIFO valid_o)
- data_i  in  W  FIFO head word (connects to FIFO data_o)
- yumi_o  out  1  word consumed this cycle (connects to FIFO yumi)
- flush_i  in  1  close the current partial beat
- valid_o  out  1  packed beat available
- rdy_i  in  1  downstream accepts beat
- data_o  out  PACK*W  packed beat; lane k = bits [k*W +: W]
- keep_o  out  PACK  lane k holds a valid word
- count_o  out  $clog2(PACK+1)  words currently accumulated

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on reset_n.
- Reset values: state=FILL, cnt=0, data_o=0, keep_o=0, valid_o=0, count_o=0. yumi_o is forced 0 while reset_n=0.
- States:
  - FILL: accumulating words.
  - HOLD: beat presented downstream.
- yumi_o = valid_i && state==FILL && reset_n. It is combinational; no word is consumed unless valid_i is high.
- Word storage: on yumi_o, data_i is written to lane cnt, keep[cnt] is set, and cnt increments. The first word popped lands in lane 0.
- FILL -> HOLD:
  - When a word is accepted with cnt==PACK-1, the beat is full, keep=all ones.
  - When flush_i=1 and (cnt>0 or a word is accepted the same cycle), the partial beat is closed.
- Flush and accept in the same cycle: the word is included first, then the beat closes.
- flush_i with cnt==0 and no accept: ignored.
- HOLD: valid_o=1. data_o and keep_o are stable until the handshake. yumi_o=0 and flush_i is ignored.
- HOLD -> FILL: on rdy_i=1. Same edge: cnt=0, keep_o=0, data_o lanes cleared to 0. No word is accepted in the handoff cycle, so minimum beat period is PACK+1 cycles.
- valid_o never drops without rdy_i; a beat is never lost or duplicated.
- Latency: the beat is valid the cycle after the final word's yumi_o edge.
- count_o = cnt. In HOLD it shows the number of words in the beat (PACK when full).
- Unused lanes in a flushed beat read 0.
- reset_n asserted mid-beat: all accumulated words are dropped immediately (asynchronous). After reset release, the first yumi_o is possible in the first cycle where valid_i=1.
- rdy_i in FILL: ignored.

Optional Feature:
- Macro: FIFO_WORD_PACKER_PARITY_EN.
- Defined: adds output parity_o, PACK bits. parity_o[k] = ^lane_k when keep_o[k]=1, else 0. It is registered alongside data_o and has reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- fifo_types package gets:
  - packer_state_e enum {FILL, HOLD}
  - constant PACKER_DEFAULT_PACK=4
  - packer_error_e {BEAT_DATA_MISMATCH, KEEP_MISMATCH, YUMI_IN_HOLD} for bench error reporting, mirroring the FIFO bench.
- word_t is reused from the package.
- Sub-module: fifo_word_packer_lane. It holds one W-bit lane register with load/clear, plus the optional parity bit. It is instantiated PACK times with generate.

Test Plan (PACK=4, W=8):
- Reset during accumulation:
  - Stimulus: 2 words accepted, then reset_n=0 mid-cycle.
  - Response: valid_o=0, count_o=0, keep_o=0 immediately; yumi_o=0 while reset held.
- Full beat:
  - Stimulus: valid_i held high with 0x11,0x22,0x33,0x44.
  - Response: yumi_o high 4 cycles; next cycle valid_o=1, data_o=0x44332211, keep_o=4'b1111, count_o=4.
- Backpressure:
  - Stimulus: as full beat, rdy_i=0 for 5 cycles with valid_i=1.
  - Response: yumi_o=0, data_o stable for all 5 cycles; after rdy_i=1, next beat starts in the following cycle.
- Flush with concurrent word:
  - Stimulus: 0xA1 accepted, then 0xB2 with flush_i=1 in the same cycle.
  - Response: data_o=0x0000B2A1, keep_o=4'b0011, count_o=2.
- Idle flush:
  - Stimulus: flush_i=1 with cnt=0, valid_i=0.
  - Response: no state change, valid_o stays 0.
- Parity:
  - Stimulus: with FIFO_WORD_PACKER_PARITY_EN defined, full beat 0x01,0x03,0x07,0x00.
  - Response: parity_o=4'b0101.

Source files
------------

// File: rtl/fifo_types_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fifo_types (package)                                     |
// | Description : Shared FIFO word type and packer types/constants.        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package fifo_types;

    typedef logic [7:0] word_t;

    localparam int PACKER_DEFAULT_PACK = 4;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_e;

    typedef enum logic [1:0] {
        BEAT_DATA_MISMATCH = 2'd0,
        KEEP_MISMATCH      = 2'd1,
        YUMI_IN_HOLD       = 2'd2
    } packer_error_e;

endpackage
`default_nettype wire

// File: rtl/fifo_word_packer_lane.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fifo_word_packer_lane                                    |
// | Description : One lane register with load/clear and optional parity.   |
// |               Parity bit present when FIFO_WORD_PACKER_PARITY_EN set.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module fifo_word_packer_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
`ifdef FIFO_WORD_PACKER_PARITY_EN
    output logic         parity_o,
`endif
    output logic [W-1:0] q_o
);

    logic [W-1:0] lane_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
        end else if (clear_i) begin
            lane_q <= '0;
        end else if (load_i) begin
            lane_q <= d_i;
        end
    end

    assign q_o = lane_q;

`ifdef FIFO_WORD_PACKER_PARITY_EN
    logic parity_q;

    // A cleared lane carries parity 0, so unused lanes never report parity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else if (clear_i) begin
            parity_q <= 1'b0;
        end else if (load_i) begin
            parity_q <= ^d_i;
        end
    end

    assign parity_o = parity_q;
`endif

endmodule
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : fifo_word_packer                                         |
// | Description : Pops FIFO words (valid/yumi) and packs PACK of them into |
// |               one beat (valid/ready), with flush and keep mask.        |
// |               Option: FIFO_WORD_PACKER_PARITY_EN adds parity_o.        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module fifo_word_packer
    import fifo_types::*;
#(
    parameter int PACK = PACKER_DEFAULT_PACK,
    parameter int W    = $bits(fifo_types::word_t)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        valid_i,
    input  logic [W-1:0]                data_i,
    output logic                        yumi_o,
    input  logic                        flush_i,
    output logic                        valid_o,
    input  logic                        rdy_i,
    output logic [PACK*W-1:0]           data_o,
    output logic [PACK-1:0]             keep_o,
`ifdef FIFO_WORD_PACKER_PARITY_EN
    output logic [PACK-1:0]             parity_o,
`endif
    output logic [$clog2(PACK+1)-1:0]   count_o
);

    localparam int CW = $clog2(PACK+1);

    localparam logic [0:0] S_FILL = FILL;
    localparam logic [0:0] S_HOLD = HOLD;

    logic [0:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [PACK-1:0] keep_q,  keep_d;
    logic            accept;
    logic            handoff;
    logic            close;

    assign accept  = valid_i && (state_q == S_FILL) && reset_n;
    assign handoff = (state_q == S_HOLD) && rdy_i;
    assign close   = (state_q == S_FILL) &&
                     ((accept && (cnt_q == CW'(PACK-1))) ||
                      (flush_i && ((cnt_q != '0) || accept)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        keep_d  = keep_q;
        if (handoff) begin
            state_d = S_FILL;
            cnt_d   = '0;
            keep_d  = '0;
        end else if (state_q == S_FILL) begin
            if (accept) begin
                cnt_d = cnt_q + 1'b1;
                for (int k = 0; k < PACK; k++) begin
                    if (cnt_q == CW'(k)) keep_d[k] = 1'b1;
                end
            end
            if (close) state_d = S_HOLD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            keep_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            keep_q  <= keep_d;
        end
    end

    for (genvar k = 0; k < PACK; k++) begin : g_lane
        fifo_word_packer_lane #(
            .W (W)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .load_i   (accept && (cnt_q == CW'(k))),
            .clear_i  (handoff),
            .d_i      (data_i),
`ifdef FIFO_WORD_PACKER_PARITY_EN
            .parity_o (parity_o[k]),
`endif
            .q_o      (data_o[k*W +: W])
        );
    end

    assign yumi_o  = accept;
    assign valid_o = (state_q == S_HOLD);
    assign keep_o  = keep_q;
    assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_fifo_word_packer                                      |
// | Description : Directed self-checking bench for fifo_word_packer.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_fifo_word_packer;

    localparam int PACK = 4;
    localparam int W    = 8;

    logic              clk;
    logic              reset_n;
    logic              valid_i;
    logic [W-1:0]      data_i;
    logic              yumi_o;
    logic              flush_i;
    logic              valid_o;
    logic              rdy_i;
    logic [PACK*W-1:0] data_o;
    logic [PACK-1:0]   keep_o;
    logic [2:0]        count_o;
`ifdef FIFO_WORD_PACKER_PARITY_EN
    logic [PACK-1:0]   parity_o;
`endif

    int n_cmp;
    int n_err;

    fifo_word_packer #(.PACK(PACK)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .yumi_o   (yumi_o),
        .flush_i  (flush_i),
        .valid_o  (valid_o),
        .rdy_i    (rdy_i),
        .data_o   (data_o),
        .keep_o   (keep_o),
`ifdef FIFO_WORD_PACKER_PARITY_EN
        .parity_o (parity_o),
`endif
        .count_o  (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one word at the negedge; it must be popped on the next posedge.
    task automatic push(input logic [W-1:0] w, input logic fl);
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = w;
        flush_i = fl;
        #1 check("yumi_push", yumi_o, 1'b1);
        @(posedge clk);
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] d,
                              input logic [3:0] kp, input logic [2:0] cn);
        #1;
        check({tag, "_valid"}, valid_o, 1'b1);
        check({tag, "_data"},  data_o,  d);
        check({tag, "_keep"},  keep_o,  kp);
        check({tag, "_count"}, count_o, cn);
    endtask

    task automatic handoff();
        rdy_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy_i = 1'b0;
        #1;
        check("handoff_valid", valid_o, 1'b0);
        check("handoff_keep",  keep_o,  4'h0);
        check("handoff_data",  data_o,  32'h0);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h00;
        flush_i = 1'b0;
        rdy_i   = 1'b0;

        #12;
        check("rst_valid", valid_o, 1'b0);
        check("rst_count", count_o, 3'd0);
        check("rst_keep",  keep_o,  4'h0);
        check("rst_data",  data_o,  32'h0);
        check("rst_yumi",  yumi_o,  1'b0);
`ifdef FIFO_WORD_PACKER_PARITY_EN
        check("rst_parity", parity_o, 4'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        valid_i = 1'b0;

        // Full beat, then backpressure with valid_i held high.
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        @(negedge clk);
        data_i = 8'h55;
        check_beat("full", 32'h44332211, 4'hF, 3'd4);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_yumi",  yumi_o,  1'b0);
            check("bp_valid", valid_o, 1'b1);
            check("bp_data",  data_o,  32'h44332211);
            @(negedge clk);
        end
        rdy_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy_i = 1'b0;
        #1;
        check("next_yumi",  yumi_o,  1'b1);
        check("next_valid", valid_o, 1'b0);
        check("next_count", count_o, 3'd0);
        @(posedge clk);
        push(8'h66, 1'b0);

        // Asynchronous reset mid-cycle with two words accumulated.
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = 8'h77;
        #1 check("pre_rst_count", count_o, 3'd2);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", valid_o, 1'b0);
        check("mid_rst_count", count_o, 3'd0);
        check("mid_rst_keep",  keep_o,  4'h0);
        check("mid_rst_data",  data_o,  32'h0);
        check("mid_rst_yumi",  yumi_o,  1'b0);
        @(posedge clk);
        #1 check("held_rst_yumi", yumi_o, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        valid_i = 1'b0;

        // Flush with a concurrent word.
        push(8'hA1, 1'b0);
        push(8'hB2, 1'b1);
        idle_inputs();
        check_beat("flush_cc", 32'h0000B2A1, 4'h3, 3'd2);
        handoff();

        // Idle flush must not close an empty beat.
        flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        check("idle_flush_valid", valid_o, 1'b0);
        check("idle_flush_count", count_o, 3'd0);
        check("idle_flush_keep",  keep_o,  4'h0);

        // Flush alone with one word held; rdy_i in FILL is ignored.
        rdy_i = 1'b1;
        push(8'h5A, 1'b0);
        idle_inputs();
        rdy_i = 1'b0;
        #1 check("fill_rdy_count", count_o, 3'd1);
        flush_i = 1'b1;
        @(posedge clk);
        idle_inputs();
        check_beat("flush_one", 32'h0000005A, 4'h1, 3'd1);
        handoff();

        // Beat used for the parity check.
        push(8'h01, 1'b0);
        push(8'h03, 1'b0);
        push(8'h07, 1'b0);
        push(8'h00, 1'b0);
        idle_inputs();
        check_beat("par_beat", 32'h00070301, 4'hF, 3'd4);
`ifdef FIFO_WORD_PACKER_PARITY_EN
        check("parity", parity_o, 4'b0101);
`endif
        handoff();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
